// File: rtl/sample_demux_8ch.sv
// Eight-channel sample distributor: routes each accepted sample to a per-channel
// holding register selected either by in_sel or by a round-robin pointer.
module sample_demux_8ch #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [2:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               auto_mode,
    input  logic               flush,
    input  logic [7:0]         out_ack,
    output logic [8*WIDTH-1:0] out_bus,
    output logic [7:0]         out_valid,
    output logic [2:0]         rr_ptr
);

    logic [8*WIDTH-1:0] bus_q, bus_d;
    logic [7:0]         valid_q, valid_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         dest;
    logic               xfer;

    assign dest     = auto_mode ? ptr_q : in_sel;
    assign in_ready = (!valid_q[dest] || out_ack[dest]) && !flush;
    assign xfer     = in_valid && in_ready;

    // Ack clears first so a same-cycle transfer into the acked channel re-sets
    // its valid bit; flush overrides both but never touches the data.
    always_comb begin
        bus_d   = bus_q;
        valid_d = valid_q & ~out_ack;
        ptr_d   = ptr_q;
        if (flush) begin
            valid_d = '0;
            ptr_d   = '0;
        end else if (xfer) begin
            for (int unsigned n = 0; n < 8; n++) begin
                if (dest == 3'(n)) begin
                    bus_d[n*WIDTH +: WIDTH] = in_data;
                    valid_d[n]              = 1'b1;
                end
            end
            if (auto_mode) begin
                ptr_d = ptr_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_q   <= '0;
            valid_q <= '0;
            ptr_q   <= '0;
        end else begin
            bus_q   <= bus_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_bus   = bus_q;
    assign out_valid = valid_q;
    assign rr_ptr    = ptr_q;

endmodule

// File: tb/tb_sample_demux_8ch.sv
// Directed bench for sample_demux_8ch: per-channel expected-sample queues drained
// by a monitor whenever a channel is consumed (out_valid & out_ack).
module tb_sample_demux_8ch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic        auto_mode;
    logic        flush;
    logic [7:0]  out_ack;
    logic [63:0] out_bus;
    logic [7:0]  out_valid;
    logic [2:0]  rr_ptr;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] expq [8][$];
    logic [63:0] exp_bus;

    sample_demux_8ch #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .auto_mode (auto_mode),
        .flush     (flush),
        .out_ack   (out_ack),
        .out_bus   (out_bus),
        .out_valid (out_valid),
        .rr_ptr    (rr_ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        for (int n = 0; n < 8; n++) expq[n].delete();
    endtask

    // Monitor: a consumed channel must present the oldest outstanding sample.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            for (int n = 0; n < 8; n++) begin
                if (out_valid[n] && out_ack[n]) begin
                    vectors++;
                    if (expq[n].size() == 0) begin
                        miscompares++;
                        $display("FAIL consume ch%0d: got %h, required no sample", n, out_bus[n*8 +: 8]);
                    end else begin
                        logic [7:0] e;
                        e = expq[n].pop_front();
                        if (out_bus[n*8 +: 8] !== e) begin
                            miscompares++;
                            $display("FAIL consume ch%0d: got %h, required %h", n, out_bus[n*8 +: 8], e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0;
        auto_mode = 1'b0; flush = 1'b0; out_ack = '0;
        #3;
        check("reset out_valid", 64'(out_valid), 64'h00);
        check("reset out_bus", out_bus, 64'h0);
        check("reset rr_ptr", 64'(rr_ptr), 64'h0);
        check("reset in_ready", 64'(in_ready), 64'h1);
        #4 rst_n = 1'b1;
        step();

        // Manual routing to channel 5
        auto_mode = 1'b0; in_sel = 3'd5; in_data = 8'hA5; in_valid = 1'b1;
        #1 check("manual in_ready", 64'(in_ready), 64'h1);
        expq[5].push_back(8'hA5);
        step();
        in_valid = 1'b0;
        check("manual out_valid", 64'(out_valid), 64'h20);
        check("manual ch5 data", 64'(out_bus[47:40]), 64'hA5);
        check("manual rr_ptr", 64'(rr_ptr), 64'h0);
        out_ack = 8'h20;
        step();
        out_ack = 8'h00;
        check("manual drained", 64'(out_valid), 64'h00);

        // Round-robin with wrap, all channels acking
        auto_mode = 1'b1; out_ack = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            in_data = 8'h10 + 8'(i); in_valid = 1'b1;
            #1 check($sformatf("auto in_ready %0d", i), 64'(in_ready), 64'h1);
            expq[i % 8].push_back(8'h10 + 8'(i));
            step();
        end
        in_valid = 1'b0;
        check("auto rr_ptr wrap", 64'(rr_ptr), 64'h1);
        step();
        out_ack = 8'h00;
        check("auto drained", 64'(out_valid), 64'h00);

        // Backpressure on channel 3; acks on other channels must not help
        auto_mode = 1'b0; in_sel = 3'd3; in_data = 8'h33; in_valid = 1'b1;
        expq[3].push_back(8'h33);
        step();
        in_data = 8'h44; out_ack = 8'hF7;
        #1 check("stall in_ready", 64'(in_ready), 64'h0);
        step();
        check("stall ch3 data", 64'(out_bus[31:24]), 64'h33);
        check("stall out_valid", 64'(out_valid), 64'h08);
        out_ack = 8'h08;
        #1 check("ack+xfer in_ready", 64'(in_ready), 64'h1);
        expq[3].push_back(8'h44);
        step();
        out_ack = 8'h00; in_valid = 1'b0;
        check("ack+xfer out_valid", 64'(out_valid), 64'h08);
        check("ack+xfer ch3 data", 64'(out_bus[31:24]), 64'h44);
        check("manual holds rr_ptr", 64'(rr_ptr), 64'h1);
        out_ack = 8'h08;
        step();

        // Advance pointer 1 -> 6 while draining, then fill all channels manually
        auto_mode = 1'b1; out_ack = 8'hFF;
        for (int i = 1; i < 6; i++) begin
            in_data = 8'h80 + 8'(i); in_valid = 1'b1;
            expq[i].push_back(8'h80 + 8'(i));
            step();
        end
        in_valid = 1'b0;
        step();
        out_ack = 8'h00;
        auto_mode = 1'b0;
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s); in_data = 8'hC0 + 8'(s); in_valid = 1'b1;
            expq[s].push_back(8'hC0 + 8'(s));
            exp_bus[s*8 +: 8] = 8'hC0 + 8'(s);
            step();
        end
        in_valid = 1'b0;
        check("fill out_valid", 64'(out_valid), 64'hFF);
        check("fill rr_ptr", 64'(rr_ptr), 64'h6);
        check("fill out_bus", out_bus, exp_bus);

        // Flush overrides a pending transfer
        auto_mode = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        #1 check("flush in_ready", 64'(in_ready), 64'h0);
        check("mode switch rr_ptr", 64'(rr_ptr), 64'h6);
        step();
        flush = 1'b0; in_valid = 1'b0;
        clear_queues();
        check("flush out_valid", 64'(out_valid), 64'h00);
        check("flush rr_ptr", 64'(rr_ptr), 64'h0);
        check("flush out_bus", out_bus, exp_bus);

        // Asynchronous reset between edges discards held data
        in_data = 8'h5A; in_valid = 1'b1;
        expq[0].push_back(8'h5A);
        step();
        in_data = 8'h5B;
        expq[1].push_back(8'h5B);
        step();
        in_valid = 1'b0;
        check("pre-reset out_valid", 64'(out_valid), 64'h03);
        #2 rst_n = 1'b0;
        clear_queues();
        #1;
        check("async out_valid", 64'(out_valid), 64'h00);
        check("async out_bus", out_bus, 64'h0);
        check("async rr_ptr", 64'(rr_ptr), 64'h0);
        check("async in_ready", 64'(in_ready), 64'h1);
        in_data = 8'h99; in_valid = 1'b1;
        step();
        check("no capture in reset", 64'(out_valid), 64'h00);
        in_data = 8'h77; rst_n = 1'b1;
        expq[0].push_back(8'h77);
        step();
        in_valid = 1'b0;
        check("post-reset out_valid", 64'(out_valid), 64'h01);
        check("post-reset ch0 data", 64'(out_bus[7:0]), 64'h77);
        check("post-reset rr_ptr", 64'(rr_ptr), 64'h1);
        out_ack = 8'hFF;
        step();
        out_ack = 8'h00;
        check("final out_valid", 64'(out_valid), 64'h00);

        for (int n = 0; n < 8; n++)
            check($sformatf("ch%0d leftover samples", n), 64'(expq[n].size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sample_demux_8ch.md
SAMPLE_DEMUX_8CH -- requirements
Module: sample_demux_8ch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the sample width in bits; the channel count SHALL be fixed at 8.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  WIDTH  sample to distribute.
REQ-005 in_sel  input  3  destination channel in manual mode.
REQ-006 in_valid  input  1  in_data/in_sel are valid this cycle.
REQ-007 in_ready  output  1  block accepts the offered sample this cycle.
REQ-008 auto_mode  input  1  1 = round-robin destination, 0 = in_sel destination.
REQ-009 flush  input  1  synchronous clear of all channel holding state.
REQ-010 out_ack  input  8  per-channel consumer acknowledge; bit n acks channel n.
REQ-011 out_bus  output  8*WIDTH  channel n holding register at bits [n*WIDTH +: WIDTH].
REQ-012 out_valid  output  8  bit n = channel n holds unconsumed data.
REQ-013 rr_ptr  output  3  current round-robin pointer.

Function
REQ-014 Destination dest SHALL be rr_ptr when auto_mode=1, else in_sel; dest is combinational from current inputs/state.
REQ-015 in_ready SHALL be combinational: 1 when out_valid[dest]=0 or out_ack[dest]=1, and flush=0; else 0.
REQ-016 A transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; no transfer otherwise.
REQ-017 On transfer, holding register dest SHALL load in_data and out_valid[dest] SHALL be 1 from the next cycle (latency 1).
REQ-018 Non-destination holding registers SHALL retain their values on a transfer.
REQ-019 out_valid[n]=1 with out_ack[n]=1 and no transfer into n SHALL clear out_valid[n] next cycle; out_bus data for n SHALL retain its value.
REQ-020 out_ack[n] while out_valid[n]=0 SHALL have no effect.
REQ-021 Simultaneous ack and transfer on the same channel SHALL load the new sample with out_valid[n] remaining 1 (no bubble, no loss).
REQ-022 Acks on multiple channels in one cycle SHALL all be honoured independently.
REQ-023 In auto mode, each transfer SHALL advance rr_ptr by 1 modulo 8 (7 wraps to 0); without a transfer rr_ptr SHALL hold.
REQ-024 In manual mode rr_ptr SHALL hold its value; switching auto_mode SHALL NOT modify rr_ptr.
REQ-025 A stalled sample (in_ready=0) SHALL be held by the sender; the block SHALL NOT skip to another channel in auto mode.
REQ-026 flush=1 SHALL clear all out_valid bits and set rr_ptr to 0 next cycle, take priority over ack and transfer, and leave out_bus unchanged.
REQ-027 Arithmetic: rr_ptr SHALL be 3-bit unsigned with natural wrap; no other arithmetic; data SHALL pass unmodified.

Reset
REQ-028 rst_n=0 SHALL immediately, independent of clk, set out_bus to all zeros, out_valid to 8'h00, rr_ptr to 0.
REQ-029 During reset in_ready SHALL evaluate to 1 (all channels empty, flush=0); no transfer SHALL be captured while rst_n=0.
REQ-030 Reset asserted mid-operation SHALL discard all held samples; first transfer after release SHALL go to channel 0 in auto mode.

Verification
REQ-031 Manual: auto=0, in_sel=5, in_data=8'hA5, in_valid 1 cycle -> next cycle out_valid=8'h20, out_bus[47:40]=8'hA5, rr_ptr=0.
REQ-032 Auto wrap: auto=1, 9 back-to-back transfers 8'h10..8'h18 with out_ack=8'hFF -> channels 0..7 receive 8'h10..8'h17, channel 0 then 8'h18, rr_ptr=1, in_ready=1 throughout.
REQ-033 Backpressure: channel 3 full, out_ack=0, in_sel=3 -> in_ready=0, out_bus unchanged; raise out_ack[3] with in_valid -> new sample loaded, out_valid[3] stays 1.
REQ-034 Flush: out_valid=8'hFF, rr_ptr=6, flush=1 with in_valid=1 -> in_ready=0, next cycle out_valid=8'h00, rr_ptr=0, out_bus unchanged.
REQ-035 Async reset: assert rst_n=0 between clock edges with data held -> out_valid=8'h00, out_bus=0, rr_ptr=0 before the next edge.
